// File: rtl/id_ex_stage.sv
// Instruction decode and ID/EX pipeline register for the 5-stage MIPS core.
// The decoder, immediate extension and load-use interlock are combinational.
// The EX-side state is one register bank with a single load enable.
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter bit ENABLE_HAZARD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [DATA_WIDTH-1:0] id_pc,
  output logic [4:0]            readAddress1,
  output logic [4:0]            readAddress2,
  input  logic [DATA_WIDTH-1:0] readData1,
  input  logic [DATA_WIDTH-1:0] readData2,
  input  logic                  flush,
  input  logic                  mem_stall,
  output logic                  stall_out,
  output logic                  ex_valid,
  output logic                  ex_regWrite,
  output logic                  ex_memRead,
  output logic                  ex_memWrite,
  output logic                  ex_aluSrc,
  output logic                  ex_branch,
  output logic [3:0]            ex_aluCtrl,
  output logic [DATA_WIDTH-1:0] ex_readData1,
  output logic [DATA_WIDTH-1:0] ex_readData2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_dest,
  output logic                  ex_illegal
);

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign rd     = id_instr[15:11];
  assign funct  = id_instr[5:0];
  assign imm16  = id_instr[15:0];

  assign readAddress1 = rs;
  assign readAddress2 = rt;

  logic       legal, d_reg_write, d_mem_read, d_mem_write, d_alu_src, d_branch;
  logic       reads_rt, zext;
  logic [3:0] d_alu_ctrl;
  logic [4:0] d_dest;

  // Opcode/funct decode; unsupported encodings leave legal low.
  always_comb begin
    legal       = 1'b0;
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_alu_src   = 1'b0;
    d_branch    = 1'b0;
    reads_rt    = 1'b0;
    zext        = 1'b0;
    d_alu_ctrl  = 4'b0000;
    d_dest      = 5'd0;
    case (opcode)
      6'h00: begin
        legal       = 1'b1;
        d_reg_write = 1'b1;
        reads_rt    = 1'b1;
        d_dest      = rd;
        case (funct)
          6'h20, 6'h21: d_alu_ctrl = 4'b0010;
          6'h22, 6'h23: d_alu_ctrl = 4'b0110;
          6'h24:        d_alu_ctrl = 4'b0000;
          6'h25:        d_alu_ctrl = 4'b0001;
          6'h27:        d_alu_ctrl = 4'b1100;
          6'h2A:        d_alu_ctrl = 4'b0111;
          default:      legal      = 1'b0;
        endcase
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        legal       = 1'b1;
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
        d_dest      = rt;
        case (opcode)
          6'h08:   d_alu_ctrl = 4'b0010;
          6'h0A:   d_alu_ctrl = 4'b0111;
          6'h0C:   begin d_alu_ctrl = 4'b0000; zext = 1'b1; end
          default: begin d_alu_ctrl = 4'b0001; zext = 1'b1; end
        endcase
      end
      6'h23: begin
        legal       = 1'b1;
        d_reg_write = 1'b1;
        d_mem_read  = 1'b1;
        d_alu_src   = 1'b1;
        d_alu_ctrl  = 4'b0010;
        d_dest      = rt;
      end
      6'h2B: begin
        legal       = 1'b1;
        d_mem_write = 1'b1;
        d_alu_src   = 1'b1;
        reads_rt    = 1'b1;
        d_alu_ctrl  = 4'b0010;
      end
      6'h04: begin
        legal      = 1'b1;
        d_branch   = 1'b1;
        reads_rt   = 1'b1;
        d_alu_ctrl = 4'b0110;
      end
      default: legal = 1'b0;
    endcase
  end

  logic [DATA_WIDTH-1:0] imm_ext;
  assign imm_ext = zext ? {{(DATA_WIDTH-16){1'b0}}, imm16}
                        : {{(DATA_WIDTH-16){imm16[15]}}, imm16};

  // Illegal encodings read no operands, so they can never trigger the interlock.
  logic uses_rs, uses_rt, load_use;
  assign uses_rs  = legal;
  assign uses_rt  = legal & reads_rt;
  assign load_use = ENABLE_HAZARD & id_valid & ex_valid & ex_memRead & (ex_dest != 5'd0) &
                    ((uses_rs & (rs == ex_dest)) | (uses_rt & (rt == ex_dest)));

  // Reset term keeps the freeze low even while mem_stall is asserted during reset.
  assign stall_out = !rst & !flush & (mem_stall | load_use);

  // Flush overrides the downstream hold; otherwise the hold freezes the bank.
  logic load_en, take, take_bad;
  assign load_en  = flush | !mem_stall;
  assign take     = !flush & !load_use & id_valid & legal;
  assign take_bad = !flush & !load_use & id_valid & !legal;

  // ID/EX register: decoded instruction, bubble, or illegal-flagged bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_regWrite  <= 1'b0;
      ex_memRead   <= 1'b0;
      ex_memWrite  <= 1'b0;
      ex_aluSrc    <= 1'b0;
      ex_branch    <= 1'b0;
      ex_aluCtrl   <= 4'b0000;
      ex_readData1 <= '0;
      ex_readData2 <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_dest      <= 5'd0;
      ex_illegal   <= 1'b0;
    end else if (load_en) begin
      ex_valid     <= take;
      ex_regWrite  <= take & d_reg_write & (d_dest != 5'd0);
      ex_memRead   <= take & d_mem_read;
      ex_memWrite  <= take & d_mem_write;
      ex_aluSrc    <= take & d_alu_src;
      ex_branch    <= take & d_branch;
      ex_aluCtrl   <= take ? d_alu_ctrl : 4'b0000;
      ex_readData1 <= take ? readData1 : '0;
      ex_readData2 <= take ? readData2 : '0;
      ex_imm       <= take ? imm_ext : '0;
      ex_pc        <= take ? id_pc : '0;
      ex_rs        <= take ? rs : 5'd0;
      ex_rt        <= take ? rt : 5'd0;
      ex_dest      <= take ? d_dest : 5'd0;
      ex_illegal   <= take_bad;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed plan followed by random instruction traffic,
// compared against a cycle-level model of the decode/interlock rules.
module tb_id_ex_stage;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, flush, mem_stall;
  logic [31:0]   id_instr;
  logic [W-1:0]  id_pc, readData1, readData2;
  logic [4:0]    readAddress1, readAddress2;
  logic          stall_out;
  logic          ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch, ex_illegal;
  logic [3:0]    ex_aluCtrl;
  logic [W-1:0]  ex_readData1, ex_readData2, ex_imm, ex_pc;
  logic [4:0]    ex_rs, ex_rt, ex_dest;

  id_ex_stage #(.DATA_WIDTH(W), .ENABLE_HAZARD(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .readAddress1(readAddress1), .readAddress2(readAddress2),
    .readData1(readData1), .readData2(readData2),
    .flush(flush), .mem_stall(mem_stall), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch),
    .ex_aluCtrl(ex_aluCtrl), .ex_readData1(ex_readData1), .ex_readData2(ex_readData2),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid, rw, mr, mw, as, br, ill, dest_dc;
    logic [3:0] alu;
    logic [W-1:0] d1, d2, imm, pc;
    logic [4:0] rs, rt, dest;
  } ex_t;

  ex_t  m;
  logic last_stall;
  int   vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What an instruction looks like once it sits in EX, straight from the ISA table.
  function automatic void model_dec(input logic [31:0] ins, input logic [W-1:0] d1, d2, pc,
                                    output ex_t e, output logic urs, output logic urt);
    logic [5:0] op, fn;
    logic [15:0] i16;
    op = ins[31:26]; fn = ins[5:0]; i16 = ins[15:0];
    e = '{default: '0};
    e.valid = 1'b1; e.rs = ins[25:21]; e.rt = ins[20:16];
    e.d1 = d1; e.d2 = d2; e.pc = pc;
    e.imm = {{(W-16){i16[15]}}, i16};
    urs = 1'b1; urt = 1'b0;
    case (op)
      6'h00: begin
        urt = 1'b1; e.rw = 1'b1; e.dest = ins[15:11];
        case (fn)
          6'h20, 6'h21: e.alu = 4'd2;
          6'h22, 6'h23: e.alu = 4'd6;
          6'h24:        e.alu = 4'd0;
          6'h25:        e.alu = 4'd1;
          6'h27:        e.alu = 4'd12;
          6'h2A:        e.alu = 4'd7;
          default:      e.ill = 1'b1;
        endcase
      end
      6'h08: begin e.alu = 4'd2; e.as = 1'b1; e.rw = 1'b1; e.dest = ins[20:16]; end
      6'h0A: begin e.alu = 4'd7; e.as = 1'b1; e.rw = 1'b1; e.dest = ins[20:16]; end
      6'h0C: begin e.alu = 4'd0; e.as = 1'b1; e.rw = 1'b1; e.dest = ins[20:16]; e.imm = W'(i16); end
      6'h0D: begin e.alu = 4'd1; e.as = 1'b1; e.rw = 1'b1; e.dest = ins[20:16]; e.imm = W'(i16); end
      6'h23: begin e.alu = 4'd2; e.as = 1'b1; e.rw = 1'b1; e.mr = 1'b1; e.dest = ins[20:16]; end
      6'h2B: begin e.alu = 4'd2; e.as = 1'b1; e.mw = 1'b1; urt = 1'b1; e.dest_dc = 1'b1; end
      6'h04: begin e.alu = 4'd6; e.br = 1'b1; urt = 1'b1; e.dest_dc = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.dest == 5'd0) e.rw = 1'b0;
    if (e.ill) begin
      e = '{default: '0};
      e.ill = 1'b1;
      urs = 1'b0; urt = 1'b0;
    end
  endfunction

  task automatic check_regs();
    chk("ex_valid", ex_valid, m.valid);       chk("ex_regWrite", ex_regWrite, m.rw);
    chk("ex_memRead", ex_memRead, m.mr);      chk("ex_memWrite", ex_memWrite, m.mw);
    chk("ex_aluSrc", ex_aluSrc, m.as);        chk("ex_branch", ex_branch, m.br);
    chk("ex_aluCtrl", ex_aluCtrl, m.alu);     chk("ex_illegal", ex_illegal, m.ill);
    chk("ex_readData1", ex_readData1, m.d1);  chk("ex_readData2", ex_readData2, m.d2);
    chk("ex_imm", ex_imm, m.imm);             chk("ex_pc", ex_pc, m.pc);
    chk("ex_rs", ex_rs, m.rs);                chk("ex_rt", ex_rt, m.rt);
    if (!m.dest_dc) chk("ex_dest", ex_dest, m.dest);
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones.
  task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic ms);
    ex_t e, nx, bub;
    logic urs, urt, lu, st;
    logic [W-1:0] d1, d2, pc;
    d1 = $urandom; d2 = $urandom; pc = $urandom;
    bub = '{default: '0};
    id_instr = ins; id_valid = v; flush = fl; mem_stall = ms;
    readData1 = d1; readData2 = d2; id_pc = pc;
    model_dec(ins, d1, d2, pc, e, urs, urt);
    lu = v && m.valid && m.mr && (m.dest != 5'd0) &&
         ((urs && ins[25:21] == m.dest) || (urt && ins[20:16] == m.dest));
    st = !fl && (ms || lu);
    #1;
    chk("stall_out", stall_out, st);
    chk("readAddress1", readAddress1, ins[25:21]);
    chk("readAddress2", readAddress2, ins[20:16]);
    if (fl)      nx = bub;
    else if (ms) nx = m;
    else if (lu) nx = bub;
    else if (v)  nx = e;
    else         nx = bub;
    @(posedge clk); #1;
    m = nx;
    last_stall = st;
    check_regs();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    logic [15:0] im;
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    case ($urandom_range(0, 7))
      0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h23;
      4: fn = 6'h24; 5: fn = 6'h25; 6: fn = 6'h27; default: fn = 6'h2A;
    endcase
    if ($urandom_range(0, 15) == 0) fn = 6'($urandom);
    case ($urandom_range(0, 10))
      0, 1:    return {6'h00, rs, rt, rd, 5'd0, fn};
      2:       return {6'h08, rs, rt, im};
      3:       return {6'h0A, rs, rt, im};
      4:       return {6'h0C, rs, rt, im};
      5:       return {6'h0D, rs, rt, im};
      6, 7:    return {6'h23, rs, rt, im};
      8:       return {6'h2B, rs, rt, im};
      9:       return {6'h04, rs, rt, im};
      default: return {6'($urandom), rs, rt, im};
    endcase
  endfunction

  initial begin
    logic [31:0] cur;
    m = '{default: '0};
    last_stall = 1'b0;
    // Reset with a valid instruction presented
    rst = 1'b1; id_valid = 1'b1; id_instr = 32'h2005FFFD; flush = 1'b0; mem_stall = 1'b1;
    id_pc = 32'h4; readData1 = 32'h1234; readData2 = 32'h5678;
    #1;
    chk("rst_stall_out", stall_out, 1'b0);
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
    rst = 1'b0; mem_stall = 1'b0;

    // addi $5,$0,-3
    step(32'h2005FFFD, 1, 0, 0);
    chk("addi_imm", ex_imm, 32'hFFFFFFFD); chk("addi_dest", ex_dest, 5'd5);
    chk("addi_alu", ex_aluCtrl, 4'b0010);  chk("addi_regWrite", ex_regWrite, 1'b1);
    // ori $6,$0,0x8000 and sub $7,$5,$6
    step(32'h34068000, 1, 0, 0);
    chk("ori_imm", ex_imm, 32'h00008000);
    step(32'h00A63822, 1, 0, 0);
    chk("sub_alu", ex_aluCtrl, 4'b0110);   chk("sub_dest", ex_dest, 5'd7);

    // lw $8,0($1); add $9,$8,$2 -> one bubble
    step(32'h8C280000, 1, 0, 0);
    step(32'h01024820, 1, 0, 0);
    chk("lu_stalled", last_stall, 1'b1);   chk("lu_bubble", ex_valid, 1'b0);
    step(32'h01024820, 1, 0, 0);
    chk("lu_released", last_stall, 1'b0);  chk("lu_add_rs", ex_rs, 5'd8);
    // lw $0 then add reading $0 -> no stall
    step(32'h8C200000, 1, 0, 0);
    step(32'h00024820, 1, 0, 0);
    chk("lw0_no_stall", last_stall, 1'b0);
    // lw $8 then addi $8,$3,1 (rt is only its destination) -> no stall
    step(32'h8C280000, 1, 0, 0);
    step(32'h20680001, 1, 0, 0);
    chk("rt_only_no_stall", last_stall, 1'b0);

    // Flush beats mem_stall and load-use
    step(32'h8C280000, 1, 0, 0);
    step(32'h01024820, 1, 1, 1);
    chk("flush_stall", last_stall, 1'b0);  chk("flush_bubble", ex_valid, 1'b0);

    // sw held in EX by mem_stall for three cycles
    step(32'hAC220004, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(32'h34068000, 1, 0, 1);
      chk("hold_sw", ex_memWrite, 1'b1);
    end
    step(32'h34068000, 1, 0, 0);
    chk("hold_release_imm", ex_imm, 32'h00008000);

    // Illegal opcode and illegal funct
    step(32'hFC000000, 1, 0, 0);
    chk("ill_op_flag", ex_illegal, 1'b1);  chk("ill_op_valid", ex_valid, 1'b0);
    step(32'h00000018, 1, 0, 0);
    chk("ill_fn_flag", ex_illegal, 1'b1);
    step(32'h2005FFFD, 1, 0, 0);
    chk("ill_cleared", ex_illegal, 1'b0);

    // Reset asserted in the middle of a load-use stall
    step(32'h8C280000, 1, 0, 0);
    id_instr = 32'h01024820; id_valid = 1'b1; #1;
    chk("pre_rst_stall", stall_out, 1'b1);
    rst = 1'b1; #1;
    chk("mid_rst_stall", stall_out, 1'b0);
    m = '{default: '0};
    check_regs();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic; a stalled instruction stays in IF/ID
    cur = rnd_instr();
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) cur = rnd_instr();
      step(cur, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Instruction-decode stage plus the ID/EX pipeline register of the 5-stage MIPS core.
- Drives the register file read addresses from the IF/ID instruction, and captures the register file read data on posedge clk.
- Decodes control, sign/zero-extends the immediate, and detects load-use hazards against the instruction it currently holds in EX, inserting a one-cycle bubble when needed.
- Handles branch flush and a downstream memory hold.

Parameters:
DATA_WIDTH, 32, width of register data, immediate and PC
ENABLE_HAZARD, 1, 1 = load-use interlock active; 0 = interlock disabled (stall_out driven only by mem_stall)

Ports:
clk  input  1  system clock; all state on posedge
rst  input  1  reset, asynchronous, active-high
id_valid  input  1  IF/ID holds a valid instruction
id_instr  input  32  instruction from IF/ID
id_pc  input  DATA_WIDTH  PC+4 of that instruction
readAddress1  output  5  combinational, = id_instr[25:21]
readAddress2  output  5  combinational, = id_instr[20:16]
readData1  input  DATA_WIDTH  register file port 1 data (valid by posedge)
readData2  input  DATA_WIDTH  register file port 2 data
flush  input  1  branch taken; squash the instruction entering EX
mem_stall  input  1  downstream hold; freeze ID/EX
stall_out  output  1  combinational; freeze PC and IF/ID
ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch  output  1 each  registered control
ex_aluCtrl  output  4  registered ALU control
ex_readData1, ex_readData2, ex_imm, ex_pc  output  DATA_WIDTH  registered data
ex_rs, ex_rt, ex_dest  output  5 each  registered register numbers
ex_illegal  output  1  registered; 1-cycle flag for an unsupported opcode or funct

Behaviour:
- Reset (async, rst=1): every registered output is 0. stall_out is 0 while rst=1.
- Decode, combinational on id_instr:
  - Opcode 0x00 is R-type. Funct map: 0x20/0x21→ADD 0010; 0x22/0x23→SUB 0110; 0x24→AND 0000; 0x25→OR 0001; 0x27→NOR 1100; 0x2A→SLT 0111. Dest = rd. regWrite=1.
  - 0x08 addi→ADD; 0x0A slti→SLT; 0x0C andi→AND; 0x0D ori→OR. aluSrc=1, dest=rt, regWrite=1.
  - 0x23 lw: ADD, aluSrc=1, memRead=1, regWrite=1, dest=rt.
  - 0x2B sw: ADD, aluSrc=1, memWrite=1, regWrite=0.
  - 0x04 beq: SUB, branch=1, regWrite=0.
  - Immediate: zero-extended for andi/ori; sign-extended for all other opcodes.
  - Dest 0 forces regWrite=0.
  - Any other opcode or funct: illegal. It enters EX as a bubble with ex_illegal=1 for one cycle.
- Operand usage: uses_rs for every supported opcode; uses_rt for R-type, sw and beq.
- load_use = ENABLE_HAZARD & id_valid & ex_valid & ex_memRead & (ex_dest≠0) & ((uses_rs & rs==ex_dest) | (uses_rt & rt==ex_dest)).
- stall_out = !flush & (mem_stall | load_use).
- Register update priority on posedge (highest first):
  1. flush: bubble loaded.
  2. mem_stall: all registers hold.
  3. load_use: bubble loaded; IF/ID holds the instruction.
  4. id_valid: decoded instruction loaded.
  5. otherwise: bubble loaded.
- Bubble contents: ex_valid and all control bits = 0. Data fields are don't-care but must be driven to 0.
- Latency: 1 cycle from ID to EX outputs. A load-use costs exactly 1 bubble, because ex_memRead is 0 the cycle after the bubble.
- Write-back needs no bypass here: the register file writes on posedge and reads on negedge, so a same-cycle write is visible in readData.
- rst asserted mid-stall clears stall_out and all state immediately.

Test Plan:
- Reset: rst=1 with id_valid=1 → all ex_* = 0, stall_out = 0. Release rst; send `addi $5,$0,-3` (0x2005FFFD) → next cycle ex_imm=0xFFFFFFFD, ex_dest=5, ex_aluCtrl=0010, ex_aluSrc=1, ex_regWrite=1.
- Zero-extend and R-type: `ori $6,$0,0x8000` → ex_imm=0x00008000. `sub $7,$5,$6` (0x00A63822) → ex_aluCtrl=0110, ex_dest=7, readAddress1=5, readAddress2=6.
- Load-use: `lw $8,0($1)` then `add $9,$8,$2`.
  - While the add is in ID: stall_out=1 for exactly 1 cycle, and ex_valid=0 the next cycle.
  - The add then enters EX with ex_rs=8.
  - Repeat with `lw $0`, or with a consumer using only rt via addi → no stall.
- Flush priority: a load-use condition with flush=1 and mem_stall=1 in the same cycle → stall_out=0, next cycle ex_valid=0.
- mem_stall: with `sw` in EX, hold mem_stall=1 for 3 cycles → all ex_* unchanged and stall_out=1; release → the next instruction loads.
- Illegal: opcode 0x3F → ex_illegal=1 and ex_valid=0 for one cycle, then 0. R-type funct 0x18 → same.
